hazard_forward_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage pipeline. It generalises the EX-operand forwarding unit in four ways:
- tracks ID/EX/MEM/WB destination tags internally instead of taking them as ports;
- detects load-use hazards and inserts bubbles;
- stalls the pipe for multi-cycle multiply/divide operations;
- optionally forwards branch operands in ID.

It sits beside the ID stage and drives the EX operand muxes, branch-compare mux and pipeline-register enables.

---
 rtl/hazard_forward_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller beside ID: tracks EX/MEM/WB dest tags, drives EX operand and ID branch-compare muxes.
// Latency: all outputs combinational from tag registers and ID inputs; tags, mul/div counter and state update on clk.
// Backpressure: load-use or branch hazards stall ID and bubble EX; mul/div holds EX and bubbles MEM. Optional macro FWD_BRANCH_EN.
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int MULDIV_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_op1,
    input  logic [REG_ADDR_W-1:0] id_op2,
    input  logic                  id_use_op1,
    input  logic                  id_use_op2,
    input  logic [1:0]            id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_muldiv,
    input  logic                  id_branch,
    input  logic                  id_flush,
    output logic [2:0]            forward_a,
    output logic [2:0]            forward_b,
    output logic [1:0]            forward_branch,
    output logic                  stall_id,
    output logic                  stall_ex,
    output logic                  bubble_ex,
    output logic                  bubble_mem,
    output logic                  md_busy
);

    localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

    typedef enum logic {RUN, MD_BUSY} md_state_t;

    typedef struct packed {
        logic                  vld;
        logic [REG_ADDR_W-1:0] op1;
        logic [REG_ADDR_W-1:0] op2;
        logic                  use_op1;
        logic                  use_op2;
        logic [1:0]            regwrite;
        logic                  memread;
    } ex_tag_t;

    typedef struct packed {
        logic                  vld;
        logic [REG_ADDR_W-1:0] op1;
        logic [1:0]            regwrite;
        logic                  memread;
    } mem_tag_t;

    typedef struct packed {
        logic                  vld;
        logic [REG_ADDR_W-1:0] op1;
        logic [1:0]            regwrite;
    } wb_tag_t;

    ex_tag_t    ex_q;
    mem_tag_t   mem_q;
    wb_tag_t    wb_q;
    md_state_t  md_state;
    logic [CNT_W-1:0] md_cnt;

    logic ex_wr, mem_wr, wb_wr;
    logic load_use, br_stall, br_chk, ex_enter;

    always_comb begin
        ex_wr  = ex_q.vld  && (ex_q.regwrite  == 2'b11);
        mem_wr = mem_q.vld && (mem_q.regwrite == 2'b11);
        wb_wr  = wb_q.vld  && (wb_q.regwrite  == 2'b11);

        // MEM is newer than WB, so it wins when both hold the register
        forward_a = 3'b000;
        if (ex_q.vld && ex_q.use_op1) begin
            if (mem_wr && mem_q.op1 == ex_q.op1)     forward_a = mem_q.memread ? 3'b100 : 3'b001;
            else if (wb_wr && wb_q.op1 == ex_q.op1)  forward_a = 3'b010;
        end
        forward_b = 3'b000;
        if (ex_q.vld && ex_q.use_op2) begin
            if (mem_wr && mem_q.op1 == ex_q.op2)     forward_b = mem_q.memread ? 3'b100 : 3'b001;
            else if (wb_wr && wb_q.op1 == ex_q.op2)  forward_b = 3'b010;
        end

        stall_ex   = (md_state == MD_BUSY);
        bubble_mem = stall_ex;
        md_busy    = (md_cnt != '0);

        // a flushed instruction is dead and must not raise hazards
        load_use = id_valid && !id_flush && ex_wr && ex_q.memread &&
                   ((id_use_op1 && ex_q.op1 == id_op1) || (id_use_op2 && ex_q.op1 == id_op2));

        br_chk = id_valid && !id_flush && id_branch;
`ifdef FWD_BRANCH_EN
        br_stall = br_chk && ((ex_wr && ex_q.op1 == id_op1) ||
                              (mem_wr && mem_q.memread && mem_q.op1 == id_op1));
        forward_branch = 2'b00;
        if (id_valid && id_branch) begin
            if (mem_wr && !mem_q.memread && mem_q.op1 == id_op1) forward_branch = 2'b01;
            else if (wb_wr && wb_q.op1 == id_op1)                forward_branch = 2'b10;
        end
`else
        br_stall = br_chk && ((ex_wr && ex_q.op1 == id_op1) ||
                              (mem_wr && mem_q.op1 == id_op1) ||
                              (wb_wr && wb_q.op1 == id_op1));
        forward_branch = 2'b00;
`endif

        stall_id  = stall_ex || load_use || br_stall;
        bubble_ex = !rst && !stall_ex && (stall_id || id_flush);
        ex_enter  = id_valid && !id_flush && !stall_id;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q.vld      <= mem_q.vld;
            wb_q.op1      <= mem_q.op1;
            wb_q.regwrite <= mem_q.regwrite;
            if (stall_ex) begin
                mem_q <= '0;
            end else begin
                mem_q.vld      <= ex_q.vld;
                mem_q.op1      <= ex_q.op1;
                mem_q.regwrite <= ex_q.regwrite;
                mem_q.memread  <= ex_q.memread;
                if (ex_enter)
                    ex_q <= '{vld: 1'b1, op1: id_op1, op2: id_op2, use_op1: id_use_op1,
                              use_op2: id_use_op2, regwrite: id_regwrite, memread: id_memread};
                else
                    ex_q <= '0;
            end
        end
    end

    // counter holds the remaining held cycles after the first EX cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_state <= RUN;
            md_cnt   <= '0;
        end else begin
            case (md_state)
                RUN: begin
                    if (ex_enter && id_muldiv && (MULDIV_LAT > 1)) begin
                        md_state <= MD_BUSY;
                        md_cnt   <= CNT_W'(MULDIV_LAT - 1);
                    end
                end
                MD_BUSY: begin
                    md_cnt <= md_cnt - CNT_W'(1);
                    if (md_cnt == CNT_W'(1))
                        md_state <= RUN;
                end
                default: begin
                    md_state <= RUN;
                    md_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed scenarios plus random traffic
// compared every cycle against an instruction-level pipeline model.
module tb_hazard_forward_ctrl;
    localparam int AW  = 4;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_use_op1, id_use_op2, id_memread, id_muldiv, id_branch, id_flush;
    logic [AW-1:0] id_op1, id_op2;
    logic [1:0]    id_regwrite;
    logic [2:0]    forward_a, forward_b;
    logic [1:0]    forward_branch;
    logic          stall_id, stall_ex, bubble_ex, bubble_mem, md_busy;

    hazard_forward_ctrl #(.REG_ADDR_W(AW), .MULDIV_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op1(id_op1), .id_op2(id_op2),
        .id_use_op1(id_use_op1), .id_use_op2(id_use_op2), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_muldiv(id_muldiv), .id_branch(id_branch), .id_flush(id_flush),
        .forward_a(forward_a), .forward_b(forward_b), .forward_branch(forward_branch),
        .stall_id(stall_id), .stall_ex(stall_ex), .bubble_ex(bubble_ex),
        .bubble_mem(bubble_mem), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int op1;
        int op2;
        bit u1;
        bit u2;
        bit wr;
        bit mr;
        bit md;
    } ins_t;

    ins_t m_ex, m_mem, m_wb;
    int   ex_age;
    int   checks = 0;
    int   failures = 0;

    logic [2:0] e_fa, e_fb;
    logic [1:0] e_fbr;
    logic       e_sid, e_sex, e_bex, e_bmem, e_md;

    function automatic ins_t empty_ins();
        ins_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic bit wrt(ins_t s, int r);
        return s.v && s.wr && (s.op1 == r);
    endfunction

    function automatic logic [2:0] fwd(bit use_it, int r);
        if (!use_it)         return 3'b000;
        if (wrt(m_mem, r))   return m_mem.mr ? 3'b100 : 3'b001;
        if (wrt(m_wb, r))    return 3'b010;
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_ex = empty_ins(); m_mem = empty_ins(); m_wb = empty_ins();
        ex_age = 0;
    endtask

    task automatic compute_exp();
        int  a, b;
        bit  ld_use, br_st;
        a = int'(id_op1);
        b = int'(id_op2);
        // a mul/div occupies EX for LAT cycles; all but the last are held
        e_sex  = m_ex.v && m_ex.md && (ex_age < LAT);
        e_fa   = fwd(m_ex.v && m_ex.u1, m_ex.op1);
        e_fb   = fwd(m_ex.v && m_ex.u2, m_ex.op2);
        ld_use = id_valid && !id_flush && m_ex.mr &&
                 ((id_use_op1 && wrt(m_ex, a)) || (id_use_op2 && wrt(m_ex, b)));
`ifdef FWD_BRANCH_EN
        br_st = id_valid && !id_flush && id_branch && (wrt(m_ex, a) || (wrt(m_mem, a) && m_mem.mr));
        if (!(id_valid && id_branch))       e_fbr = 2'b00;
        else if (wrt(m_mem, a) && !m_mem.mr) e_fbr = 2'b01;
        else if (wrt(m_wb, a))               e_fbr = 2'b10;
        else                                 e_fbr = 2'b00;
`else
        br_st = id_valid && !id_flush && id_branch && (wrt(m_ex, a) || wrt(m_mem, a) || wrt(m_wb, a));
        e_fbr = 2'b00;
`endif
        e_sid  = e_sex || ld_use || br_st;
        e_bex  = !e_sex && (e_sid || id_flush);
        e_bmem = e_sex;
        e_md   = e_sex;
    endtask

    task automatic model_step();
        ins_t n;
        m_wb = m_mem;
        if (e_sex) begin
            m_mem  = empty_ins();
            ex_age = ex_age + 1;
        end else begin
            m_mem = m_ex;
            if (e_sid || id_flush || !id_valid) begin
                m_ex = empty_ins();
            end else begin
                n.v = 1'b1; n.op1 = int'(id_op1); n.op2 = int'(id_op2);
                n.u1 = id_use_op1; n.u2 = id_use_op2; n.wr = (id_regwrite == 2'b11);
                n.mr = id_memread; n.md = id_muldiv;
                m_ex = n;
            end
            ex_age = 1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic settle();
        logic [12:0] dv, ev;
        #4;
        compute_exp();
        dv = {forward_a, forward_b, forward_branch, stall_id, stall_ex, bubble_ex, bubble_mem, md_busy};
        ev = {e_fa, e_fb, e_fbr, e_sid, e_sex, e_bex, e_bmem, e_md};
        checks++;
        if (dv !== ev) begin
            failures++;
            $display("FAIL model_cmp t=%0t got=%b expected=%b (fa fb fbr sid sex bex bmem md)", $time, dv, ev);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        compute_exp();
        model_step();
        #1;
    endtask

    task automatic set_id(input bit v, input int o1, input int o2, input bit u1, input bit u2,
                          input int rw, input bit mr, input bit md, input bit br, input bit fl);
        id_valid = v; id_op1 = AW'(o1); id_op2 = AW'(o2);
        id_use_op1 = u1; id_use_op2 = u2; id_regwrite = 2'(rw);
        id_memread = mr; id_muldiv = md; id_branch = br; id_flush = fl;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            settle();
            tick();
        end
    endtask

    task automatic all_zero(input string name);
        chk({name, "_fa"},   8'(forward_a), 8'd0);
        chk({name, "_fb"},   8'(forward_b), 8'd0);
        chk({name, "_fbr"},  8'(forward_branch), 8'd0);
        chk({name, "_sid"},  8'(stall_id), 8'd0);
        chk({name, "_sex"},  8'(stall_ex), 8'd0);
        chk({name, "_bex"},  8'(bubble_ex), 8'd0);
        chk({name, "_bmem"}, 8'(bubble_mem), 8'd0);
        chk({name, "_md"},   8'(md_busy), 8'd0);
    endtask

    task automatic run_mul(input string tag);
        idle(3);
        set_id(1, 2, 2, 1, 1, 3, 0, 1, 0, 0);
        settle();
        chk({tag, "_enter_sex"}, 8'(stall_ex), 8'd0);
        tick();
        set_id(1, 9, 9, 1, 1, 3, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            settle();
            chk({tag, "_sex"},  8'(stall_ex),   8'(k < LAT - 1));
            chk({tag, "_md"},   8'(md_busy),    8'(k < LAT - 1));
            chk({tag, "_bmem"}, 8'(bubble_mem), 8'(k < LAT - 1));
            chk({tag, "_sid"},  8'(stall_id),   8'(k < LAT - 1));
            chk({tag, "_bex"},  8'(bubble_ex),  8'd0);
            tick();
        end
        idle(1);
    endtask

    initial begin
        int n_br;
        logic [1:0] fbr_exp;
        rst = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        settle();
        all_zero("post_reset");
        tick();

        // ALU results forwarded from MEM, MEM-over-WB, and WB only
        set_id(1, 3, 0, 1, 0, 3, 0, 0, 0, 0); settle(); tick();
        settle(); tick();
        settle(); chk("fwd_mem", 8'(forward_a), 8'd1); tick();
        set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); chk("fwd_mem_over_wb", 8'(forward_a), 8'd1); tick();
        set_id(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        settle(); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); chk("fwd_wb", 8'(forward_a), 8'd2); tick();

        // load-use: one stall, consumer then catches the load in WB
        idle(3);
        set_id(1, 5, 0, 0, 0, 3, 1, 0, 0, 0); settle(); tick();
        set_id(1, 1, 5, 0, 1, 0, 0, 0, 0, 0);
        settle(); chk("lu_sid", 8'(stall_id), 8'd1); chk("lu_bex", 8'(bubble_ex), 8'd1); tick();
        settle(); chk("lu_sid_after", 8'(stall_id), 8'd0); chk("lu_bex_after", 8'(bubble_ex), 8'd0); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); chk("lu_fwd_b", 8'(forward_b), 8'd2); tick();

        // load-use killed by flush
        idle(3);
        set_id(1, 5, 0, 0, 0, 3, 1, 0, 0, 0); settle(); tick();
        set_id(1, 1, 5, 0, 1, 0, 0, 0, 0, 1);
        settle(); chk("flush_sid", 8'(stall_id), 8'd0); chk("flush_bex", 8'(bubble_ex), 8'd1); tick();

        run_mul("mul");

        // branch on a register produced by an ALU op just ahead
        idle(3);
`ifdef FWD_BRANCH_EN
        n_br = 1; fbr_exp = 2'b01;
`else
        n_br = 3; fbr_exp = 2'b00;
`endif
        set_id(1, 7, 0, 1, 0, 3, 0, 0, 0, 0); settle(); tick();
        set_id(1, 7, 0, 1, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k <= n_br; k++) begin
            settle();
            chk("br_sid", 8'(stall_id),  8'(k < n_br));
            chk("br_bex", 8'(bubble_ex), 8'(k < n_br));
            if (k == n_br) chk("br_fwd", 8'(forward_branch), 8'(fbr_exp));
            tick();
        end
        idle(3);

        // asynchronous reset in the middle of a mul/div hold
        set_id(1, 2, 2, 1, 1, 3, 0, 1, 0, 0); settle(); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); chk("pre_rst_sex", 8'(stall_ex), 8'd1);
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        #1;
        all_zero("async_rst");
        @(posedge clk); @(posedge clk);
        #1;
        model_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        settle(); all_zero("rst_release"); tick();
        run_mul("mul_after_rst");

        // random traffic on a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            set_id($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   ($urandom_range(0, 1) == 1) ? 3 : $urandom_range(0, 3),
                   $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 8,
                   $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10);
            settle();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
